mem_decoder: RTL and testbench
==============================

# mem_decoder

Parametrised single-master memory-bus decoder: routes one CPU request (valid/instr/addr/wdata/wstrb) to one of NSLV slaves by address region and returns that slave's rdata/ready. It sits between `cpu` and the peripheral/memory slaves at SoC level. It adds a transaction state machine that ignores stray or unselected slave responses. It returns a decode-error response for unmapped addresses and a timeout-error response for unresponsive slaves.

## Interface
Parameters:
- NSLV, 4, number of slave ports (1..16)
- BASE_ADDR, {NSLV{32'h0}}, packed NSLV×32, inclusive region base per slave (slot k = bits [32k+31:32k])
- TOP_ADDR, {NSLV{32'h0}}, packed NSLV×32, exclusive region top per slave
- REBASE, {NSLV{1'b1}}, per-slave bit: 1 = slave sees addr − BASE_ADDR[k], 0 = full address
- TIMEOUT, 1024, cycles to wait for slave_ready before error; 0 disables timeout

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- memory_valid  in  1  single-cycle request pulse from CPU
- memory_instr  in  1  instruction-fetch qualifier
- memory_addr  in  32  byte address
- memory_wdata  in  32  write data
- memory_wstrb  in  4  byte strobes; 0 = read
- memory_rdata  out  32  response data
- memory_ready  out  1  single-cycle response pulse
- memory_error  out  1  qualifies memory_ready: decode or timeout error
- busy  out  1  transaction outstanding
- slave_valid  out  NSLV  one-hot request pulse
- slave_instr  out  1  broadcast
- slave_addr  out  NSLV×32  per-slave (rebased) address
- slave_wdata  out  32  broadcast
- slave_wstrb  out  4  broadcast
- slave_rdata  in  NSLV×32  per-slave read data
- slave_ready  in  NSLV  per-slave response pulse

## Operation
- States: IDLE, BUSY, ERR.
- Decode is combinational on memory_addr. Slave k hits when BASE_ADDR[k] ≤ addr < TOP_ADDR[k], using an unsigned 32-bit compare. On overlapping regions, the lowest index wins.
- IDLE + memory_valid + hit k:
  - slave_valid[k]=1 in the same cycle.
  - Latch sel=k and the instr/addr/wdata/wstrb.
  - Next state BUSY, count=0.
- IDLE + memory_valid + no hit: latch nothing, next state ERR.
- BUSY:
  - slave_valid=0.
  - Watch only slave_ready[sel]. When it is 1, in the same cycle: memory_ready=1, memory_rdata=slave_rdata[sel], memory_error=0. Next state IDLE.
  - Otherwise count+1. If TIMEOUT≠0 and count==TIMEOUT−1: memory_ready=1, memory_error=1, memory_rdata=0. Next state IDLE.
- ERR: memory_ready=1, memory_error=1, memory_rdata=0 for one cycle, then IDLE.
- slave_ready from an unselected slave, or any slave_ready in IDLE/ERR, is ignored. This covers late responses after a timeout.
- memory_valid while BUSY/ERR is a protocol violation. It is ignored: no slave_valid, no state change.
- Address output:
  - slave_addr[k] = addr − BASE_ADDR[k] (mod 2^32) if REBASE[k], else addr.
  - addr is memory_addr in IDLE and the latched address otherwise.
- slave_instr/wdata/wstrb: memory_* in IDLE, latched values otherwise. They are stable for the whole of BUSY.
- busy = (state≠IDLE).
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset (synchronous): state IDLE, count 0, latches 0. All outputs 0: slave_valid, memory_ready, memory_error, memory_rdata, busy.
- A reset mid-transaction aborts it. No memory_ready is issued, and a subsequent slave_ready is ignored.
- Request-to-slave latency: 0 cycles (slave_valid is combinational from memory_valid in IDLE).
- Response latency: 0 added cycles (memory_ready is in the same cycle as slave_ready[sel]). Minimum round trip is 1 cycle after the request.
- Decode error: memory_ready arrives exactly 1 cycle after memory_valid.
- Timeout: memory_ready+memory_error arrives exactly TIMEOUT cycles after memory_valid.
- Simultaneous slave_ready[sel] and timeout in the same cycle: ready wins, memory_error=0.
- Back-to-back: a new memory_valid is accepted in the cycle after memory_ready (state is IDLE).
- memory_ready, memory_error and slave_valid are each high for exactly one cycle per transaction.

## Test plan
Parameters for all scenarios: NSLV=4, TIMEOUT=16, REBASE=4'b1101.

| Slave | Region | REBASE |
|---|---|---|
| 0 | 0x0000_0000–0x0001_0000 | 1 |
| 1 | 0x0010_0000–0x0010_0008 | 0 |
| 2 | 0x0200_0000–0x0200_C000 | 1 |
| 3 | 0x8000_0000–0xC000_0000 | 1 |

- Read to slave 3, addr 0x8000_0010, slave_ready[3] 3 cycles later with rdata 0xDEADBEEF:
  - slave_valid=4'b1000 in the same cycle, slave_addr[3]=0x10.
  - memory_ready=1, rdata=0xDEADBEEF, error=0 in the cycle of slave_ready.
- Write to 0x0010_0004, wstrb 4'b0001, wdata 0xA5:
  - slave_valid[1]=1, slave_addr[1]=0x0010_0004 (no rebase), wstrb/wdata stable until slave_ready[1].
- Access to 0x5000_0000:
  - No slave_valid.
  - Next cycle memory_ready=1, memory_error=1, rdata=0.
- Read to slave 2, no response:
  - memory_ready=1 and memory_error=1 exactly 16 cycles after the request.
  - A slave_ready[2] injected 2 cycles later produces no memory_ready.
- Spurious responses: slave_ready[0] pulsed while slave 2 is selected, and slave_ready[1] pulsed in IDLE.
  - No memory_ready in either case.
  - slave_ready[2] later completes the transaction normally.
- Reset asserted while BUSY on slave 0:
  - Next cycle all outputs 0 and busy=0.
  - A later slave_ready[0] is ignored.
  - The next request to 0x0000_0100 gives slave_addr[0]=0x100.

Source files
------------

// File: rtl/mem_decoder.sv
// rtl/mem_decoder.sv - single-master bus decoder routing CPU requests to NSLV address-mapped slaves
module mem_decoder #(
    parameter int                   NSLV      = 4,
    parameter logic [NSLV*32-1:0]   BASE_ADDR = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0]   TOP_ADDR  = {NSLV{32'h0}},
    parameter logic [NSLV-1:0]      REBASE    = {NSLV{1'b1}},
    parameter int                   TIMEOUT   = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                memory_valid,
    input  logic                memory_instr,
    input  logic [31:0]         memory_addr,
    input  logic [31:0]         memory_wdata,
    input  logic [3:0]          memory_wstrb,
    output logic [31:0]         memory_rdata,
    output logic                memory_ready,
    output logic                memory_error,
    output logic                busy,
    output logic [NSLV-1:0]     slave_valid,
    output logic                slave_instr,
    output logic [NSLV*32-1:0]  slave_addr,
    output logic [31:0]         slave_wdata,
    output logic [3:0]          slave_wstrb,
    input  logic [NSLV*32-1:0]  slave_rdata,
    input  logic [NSLV-1:0]     slave_ready
);
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t         state_q;
    logic [CW-1:0]  count_q;
    logic [SW-1:0]  sel_q;
    logic           instr_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;

    logic           hit;
    logic [SW-1:0]  hit_idx;
    logic           ready_sel;
    logic [31:0]    rdata_sel;
    logic           sel_ready;
    logic           timed_out;
    logic           idle;
    logic [31:0]    addr_mux;

    // Scan from the top index down so the lowest matching region wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (memory_addr >= BASE_ADDR[k*32 +: 32] && memory_addr < TOP_ADDR[k*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    always_comb begin
        ready_sel = 1'b0;
        rdata_sel = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (sel_q == SW'(k)) begin
                ready_sel = slave_ready[k];
                rdata_sel = slave_rdata[k*32 +: 32];
            end
        end
    end

    assign idle      = (state_q == IDLE);
    assign sel_ready = (state_q == BUSY) && ready_sel;
    assign timed_out = (state_q == BUSY) && !ready_sel && (TIMEOUT != 0) && (count_q == CNT_LAST);

    assign memory_ready = sel_ready || timed_out || (state_q == ERR);
    assign memory_error = timed_out || (state_q == ERR);
    assign memory_rdata = sel_ready ? rdata_sel : 32'h0;
    assign busy         = !idle;

    assign addr_mux    = idle ? memory_addr  : addr_q;
    assign slave_instr = idle ? memory_instr : instr_q;
    assign slave_wdata = idle ? memory_wdata : wdata_q;
    assign slave_wstrb = idle ? memory_wstrb : wstrb_q;

    always_comb begin
        slave_valid = '0;
        slave_addr  = '0;
        for (int k = 0; k < NSLV; k++) begin
            slave_valid[k] = idle && memory_valid && hit && (hit_idx == SW'(k));
            slave_addr[k*32 +: 32] = REBASE[k] ? (addr_mux - BASE_ADDR[k*32 +: 32]) : addr_mux;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            sel_q   <= '0;
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memory_valid) begin
                        if (hit) begin
                            state_q <= BUSY;
                            count_q <= '0;
                            sel_q   <= hit_idx;
                            instr_q <= memory_instr;
                            addr_q  <= memory_addr;
                            wdata_q <= memory_wdata;
                            wstrb_q <= memory_wstrb;
                        end else begin
                            state_q <= ERR;
                        end
                    end
                end
                BUSY: begin
                    if (sel_ready || timed_out) begin
                        state_q <= IDLE;
                    end else if (count_q != {CW{1'b1}}) begin
                        count_q <= count_q + CW'(1);
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_decoder.sv
// tb/tb_mem_decoder.sv - self-checking bench for mem_decoder: vector table, corner sequences, random traffic
module tb_mem_decoder;
    localparam int NSLV = 4;
    localparam int TO   = 16;
    localparam logic [127:0] BASE = {32'h8000_0000, 32'h0200_0000, 32'h0010_0000, 32'h0000_0000};
    localparam logic [127:0] TOP  = {32'hC000_0000, 32'h0200_C000, 32'h0010_0008, 32'h0001_0000};
    localparam logic [3:0]   RB   = 4'b1101;

    logic          clock = 1'b0;
    logic          reset;
    logic          memory_valid, memory_instr;
    logic [31:0]   memory_addr, memory_wdata, memory_rdata;
    logic [3:0]    memory_wstrb;
    logic          memory_ready, memory_error, busy;
    logic [3:0]    slave_valid;
    logic          slave_instr;
    logic [127:0]  slave_addr;
    logic [31:0]   slave_wdata;
    logic [3:0]    slave_wstrb;
    logic [127:0]  slave_rdata;
    logic [3:0]    slave_ready;

    mem_decoder #(
        .NSLV(NSLV), .BASE_ADDR(BASE), .TOP_ADDR(TOP), .REBASE(RB), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
        .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready), .memory_error(memory_error), .busy(busy),
        .slave_valid(slave_valid), .slave_instr(slave_instr), .slave_addr(slave_addr),
        .slave_wdata(slave_wdata), .slave_wstrb(slave_wstrb),
        .slave_rdata(slave_rdata), .slave_ready(slave_ready)
    );

    always #5 clock = ~clock;

    // Memory map as plain numbers, independent of the packed DUT parameters.
    longint unsigned rlo[4] = '{64'h0, 64'h0010_0000, 64'h0200_0000, 64'h8000_0000};
    longint unsigned rhi[4] = '{64'h0001_0000, 64'h0010_0008, 64'h0200_C000, 64'hC000_0000};
    bit              rreb[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          rsl;
        int          dly;
        logic [31:0] rd;
        logic [3:0]  spur;
        logic [3:0]  esv;
        logic [31:0] esa;
        int          elat;
        logic        eerr;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[10];

    function automatic int ref_decode(input logic [31:0] a);
        longint unsigned ax = {32'h0, a};
        for (int k = 0; k < 4; k++)
            if (ax >= rlo[k] && ax < rhi[k]) return k;
        return -1;
    endfunction

    function automatic logic [31:0] ref_saddr(input int k, input logic [31:0] a);
        longint unsigned d = ({32'h0, a} + 64'h1_0000_0000 - rlo[k]) % 64'h1_0000_0000;
        return rreb[k] ? d[31:0] : a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Starts and ends 1ns after a rising edge with the DUT idle.
    task automatic do_txn(input vec_t v, output logic [3:0] sv, output logic [31:0] sa,
                          output int lat, output logic er, output logic [31:0] rdat,
                          output logic stab, output logic idle0);
        memory_valid = 1'b1; memory_addr = v.addr; memory_wdata = v.wdata;
        memory_wstrb = v.wstrb; memory_instr = v.instr; slave_ready = 4'b0;
        @(negedge clock);
        sv    = slave_valid;
        sa    = slave_addr[v.rsl*32 +: 32];
        idle0 = !memory_ready && !memory_error && !busy;
        stab  = (slave_wdata == v.wdata) && (slave_wstrb == v.wstrb) && (slave_instr == v.instr);
        lat = 0; er = 1'b0; rdat = 32'h0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clock); #1;
            memory_valid = 1'b0;
            memory_addr  = $urandom; memory_wdata = $urandom;
            memory_wstrb = 4'($urandom); memory_instr = 1'($urandom);
            slave_rdata  = {$urandom, $urandom, $urandom, $urandom};
            slave_ready  = (c == 1) ? v.spur : 4'b0;
            if (c == v.dly) begin
                slave_ready[v.rsl] = 1'b1;
                slave_rdata[v.rsl*32 +: 32] = v.rd;
            end
            @(negedge clock);
            if (memory_ready) begin
                lat = c; er = memory_error; rdat = memory_rdata;
            end else if (slave_valid != 4'b0 || !busy || slave_wdata != v.wdata ||
                         slave_wstrb != v.wstrb || slave_instr != v.instr ||
                         slave_addr[v.rsl*32 +: 32] != sa) begin
                stab = 1'b0;
            end
        end
        @(posedge clock); #1;
        slave_ready = 4'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [3:0] sv; logic [31:0] sa, rdat; int lat; logic er, stab, idle0;
        do_txn(v, sv, sa, lat, er, rdat, stab, idle0);
        chk({tag, ".idle_before"}, 32'(idle0), 32'd1);
        chk({tag, ".slave_valid"}, 32'(sv), 32'(v.esv));
        if (v.esv != 4'b0) chk({tag, ".slave_addr"}, sa, v.esa);
        chk({tag, ".latency"}, 32'(lat), 32'(v.elat));
        chk({tag, ".error"}, 32'(er), 32'(v.eerr));
        chk({tag, ".rdata"}, rdat, v.erd);
        chk({tag, ".stable"}, 32'(stab), 32'd1);
    endtask

    function automatic vec_t model_vec(input logic [31:0] a, input int dly, input logic [3:0] spur_raw);
        vec_t v;
        int   k = ref_decode(a);
        v.addr = a; v.wdata = $urandom; v.wstrb = 4'($urandom); v.instr = 1'($urandom);
        v.rsl  = (k < 0) ? 0 : k;
        v.dly  = dly; v.rd = $urandom;
        v.spur = spur_raw & ~(4'b1 << v.rsl);
        if (k < 0) begin
            v.esv = 4'b0; v.esa = 32'h0; v.elat = 1; v.eerr = 1'b1; v.erd = 32'h0;
        end else begin
            v.esv  = 4'b1 << k;
            v.esa  = ref_saddr(k, a);
            v.eerr = (dly == 0 || dly > TO);
            v.elat = v.eerr ? TO : dly;
            v.erd  = v.eerr ? 32'h0 : v.rd;
        end
        return v;
    endfunction

    initial begin
        vec_t v;
        reset = 1'b1; memory_valid = 1'b0; memory_instr = 1'b0; memory_addr = '0;
        memory_wdata = '0; memory_wstrb = '0; slave_rdata = '0; slave_ready = '0;

        tbl[0] = '{32'h8000_0010, 32'h0, 4'h0, 1'b0, 3, 3,  32'hDEAD_BEEF, 4'b0001, 4'b1000, 32'h10,        3,  1'b0, 32'hDEAD_BEEF};
        tbl[1] = '{32'h0010_0004, 32'hA5, 4'h1, 1'b0, 1, 2, 32'h0000_1234, 4'b0000, 4'b0010, 32'h0010_0004, 2,  1'b0, 32'h0000_1234};
        tbl[2] = '{32'h5000_0000, 32'h0, 4'h0, 1'b0, 0, 0,  32'h0,         4'b0000, 4'b0000, 32'h0,         1,  1'b1, 32'h0};
        tbl[3] = '{32'h0200_0100, 32'h0, 4'h0, 1'b1, 2, 0,  32'h0,         4'b0000, 4'b0100, 32'h100,       TO, 1'b1, 32'h0};
        tbl[4] = '{32'h0000_FFFC, 32'h7, 4'hF, 1'b0, 0, TO, 32'hCAFE_0001, 4'b0000, 4'b0001, 32'hFFFC,      TO, 1'b0, 32'hCAFE_0001};
        tbl[5] = '{32'h0001_0000, 32'h0, 4'h0, 1'b0, 0, 0,  32'h0,         4'b0000, 4'b0000, 32'h0,         1,  1'b1, 32'h0};
        tbl[6] = '{32'hBFFF_FFFC, 32'h0, 4'h0, 1'b0, 3, 1,  32'h1111_2222, 4'b0000, 4'b1000, 32'h3FFF_FFFC, 1,  1'b0, 32'h1111_2222};
        tbl[7] = '{32'hC000_0000, 32'h0, 4'h0, 1'b0, 0, 0,  32'h0,         4'b0000, 4'b0000, 32'h0,         1,  1'b1, 32'h0};
        tbl[8] = '{32'h0200_0000, 32'h0, 4'h0, 1'b0, 2, 17, 32'h5555_AAAA, 4'b0000, 4'b0100, 32'h0,         TO, 1'b1, 32'h0};
        tbl[9] = '{32'h0010_0008, 32'h0, 4'h0, 1'b0, 0, 0,  32'h0,         4'b0000, 4'b0000, 32'h0,         1,  1'b1, 32'h0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset.memory_ready", 32'(memory_ready), 32'd0);
        chk("reset.memory_error", 32'(memory_error), 32'd0);
        chk("reset.memory_rdata", memory_rdata, 32'h0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.slave_valid", 32'(slave_valid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Late response two cycles after a timeout must be dropped.
        v = model_vec(32'h0200_0200, 0, 4'b0);
        run_vec(v, "late");
        @(posedge clock); #1;
        slave_ready = 4'b0100;
        @(negedge clock);
        chk("late.no_ready", 32'(memory_ready), 32'd0);
        chk("late.idle", 32'(busy), 32'd0);
        @(posedge clock); #1;
        slave_ready = 4'b0;

        // Stray ready in IDLE, then a foreign ready while slave 2 is selected.
        slave_ready = 4'b0010;
        @(negedge clock);
        chk("idle_spur.no_ready", 32'(memory_ready), 32'd0);
        @(posedge clock); #1;
        slave_ready = 4'b0;
        @(negedge clock);
        chk("idle_spur.still_idle", 32'(busy), 32'd0);
        @(posedge clock); #1;
        v = model_vec(32'h0200_0040, 5, 4'b0001);
        run_vec(v, "busy_spur");

        // Reset while BUSY on slave 0 aborts the transaction.
        memory_valid = 1'b1; memory_addr = 32'h0000_0200; memory_wstrb = 4'h0;
        @(posedge clock); #1;
        memory_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst.memory_ready", 32'(memory_ready), 32'd0);
        chk("midrst.memory_error", 32'(memory_error), 32'd0);
        chk("midrst.memory_rdata", memory_rdata, 32'h0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.slave_valid", 32'(slave_valid), 32'd0);
        @(posedge clock); #1;
        slave_ready = 4'b0001; slave_rdata[31:0] = 32'h0BAD_0BAD;
        @(negedge clock);
        chk("midrst.late_ready", 32'(memory_ready), 32'd0);
        @(posedge clock); #1;
        slave_ready = 4'b0;
        v = model_vec(32'h0000_0100, 2, 4'b0);
        run_vec(v, "after_rst");

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int p = $urandom_range(0, 5);
            if (p < 4) a = 32'(rlo[p] + 64'($urandom_range(0, 32'(rhi[p] - rlo[p] - 1))));
            else if (p == 4) a = $urandom;
            else a = 32'(rhi[$urandom_range(0, 3)]);
            v = model_vec(a, $urandom_range(0, 20), 4'($urandom_range(0, 15)));
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
